// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard/redirect controller:
// FSM state encodings, statistics counter indices and the register-match
// helper used by both the load-use and the redirect decode.
package hazard_ctrl_pkg;

    // Width of the hazard FSM state register.
    localparam int HZ_STATE_BIT = 2;

    // RUN: normal issue; DRAIN: let DM/WB retire after a syscall exit;
    // HALTED: core stopped until a go pulse.
    typedef enum logic [HZ_STATE_BIT-1:0] {
        HZ_RUN    = 2'd0,
        HZ_DRAIN  = 2'd1,
        HZ_HALTED = 2'd2
    } hz_state_e;

    // Slot of each statistic in the counter bank.
    localparam int STAT_CYCLE    = 0;
    localparam int STAT_STALL    = 1;
    localparam int STAT_FLUSH    = 2;
    localparam int STAT_REDIRECT = 3;
    localparam int STAT_NUM      = 4;

    // A source matches a producer only if the consumer really reads the
    // register, the producer really writes it, and it is not $0.
    function automatic logic reg_match(input logic [4:0] src,
                                       input logic       used,
                                       input logic [4:0] dst,
                                       input logic       wen);
        return used && wen && (src != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_stat_cnt.sv
// Single wrapping statistics counter with increment and synchronous clear.
module hazard_stat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;

    // Count up by one per enabled cycle, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!clear_n) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and redirect control for the 5-stage MIPS32 pipeline, sitting in
// ID just upstream of the ID/EX register. Produces the load-use bubble
// request, the four forwarding selects, the stage enables and a
// syscall-halt drain FSM. Statistics counters exist only when the
// HAZ_STATS_EN macro is defined; otherwise the count outputs read 0.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             rs_used,
    input  logic             rt_used,
    input  logic [4:0]       req_w_id_ex,
    input  logic             w_en_id_ex,
    input  logic             memtoreg_id_ex,
    input  logic [4:0]       req_w_ex_dm,
    input  logic             w_en_ex_dm,
    input  logic             jp_success,
    input  logic             halt_req,
    input  logic             go,
    output logic             load_use,
    output logic             redirect_regA_ex_dm,
    output logic             redirect_regA_dm_wb,
    output logic             redirect_regB_ex_dm,
    output logic             redirect_regB_dm_wb,
    output logic             en_pc,
    output logic             en_if_id,
    output logic             en_id_ex,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    // Drain counter runs 0 .. DRAIN_CYCLES-1 while in DRAIN.
    localparam int              DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

    hz_state_e        state_q, state_d;
    logic [DRN_W-1:0] drain_q, drain_d;

    // Raw (un-gated) hazard decode, valid in every state.
    logic a_id_hit, b_id_hit, a_dm_hit, b_dm_hit;
    logic lu_raw;
    logic a_ex_dm_raw, b_ex_dm_raw, a_dm_wb_raw, b_dm_wb_raw;
    logic any_redirect_raw;

    // Source/destination overlap against both in-flight producers.
    always_comb begin
        a_id_hit = reg_match(rs_id, rs_used, req_w_id_ex, w_en_id_ex);
        b_id_hit = reg_match(rt_id, rt_used, req_w_id_ex, w_en_id_ex);
        a_dm_hit = reg_match(rs_id, rs_used, req_w_ex_dm, w_en_ex_dm);
        b_dm_hit = reg_match(rt_id, rt_used, req_w_ex_dm, w_en_ex_dm);

        // A load in ID/EX cannot forward from EX yet: bubble instead.
        lu_raw = (a_id_hit || b_id_hit) && memtoreg_id_ex;

        // The younger producer (ID/EX) wins over the older one (EX/DM).
        a_ex_dm_raw = a_id_hit && !memtoreg_id_ex;
        b_ex_dm_raw = b_id_hit && !memtoreg_id_ex;
        a_dm_wb_raw = a_dm_hit && !a_ex_dm_raw;
        b_dm_wb_raw = b_dm_hit && !b_ex_dm_raw;

        any_redirect_raw = a_ex_dm_raw || b_ex_dm_raw || a_dm_wb_raw || b_dm_wb_raw;
    end

    // State and drain counter; reset drops straight back to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic plus state-dependent gating of enables and flags.
    always_comb begin
        state_d             = state_q;
        drain_d             = drain_q;
        load_use            = lu_raw;
        redirect_regA_ex_dm = a_ex_dm_raw;
        redirect_regB_ex_dm = b_ex_dm_raw;
        redirect_regA_dm_wb = a_dm_wb_raw;
        redirect_regB_dm_wb = b_dm_wb_raw;
        en_pc               = 1'b0;
        en_if_id            = 1'b0;
        en_id_ex            = 1'b0;
        halted              = 1'b0;

        unique case (state_q)
            HZ_RUN: begin
                en_pc    = !lu_raw;
                en_if_id = !lu_raw;
                en_id_ex = 1'b1;
                // A syscall exit outranks any branch flush or bubble.
                if (halt_req) begin
                    state_d = HZ_DRAIN;
                    drain_d = '0;
                end
            end
            HZ_DRAIN: begin
                // Front end frozen; ID/EX keeps clocking in bubbles.
                en_id_ex            = 1'b1;
                load_use            = 1'b0;
                redirect_regA_ex_dm = 1'b0;
                redirect_regB_ex_dm = 1'b0;
                redirect_regA_dm_wb = 1'b0;
                redirect_regB_dm_wb = 1'b0;
                if (drain_q == DRN_LAST) begin
                    state_d = HZ_HALTED;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            HZ_HALTED: begin
                halted = 1'b1;
                if (go) begin
                    state_d = HZ_RUN;
                end
            end
            default: begin
                state_d = HZ_RUN;
                drain_d = '0;
            end
        endcase
    end

`ifdef HAZ_STATS_EN
    logic [STAT_NUM-1:0] stat_inc;
    logic [CNT_W-1:0]    stat_val [STAT_NUM];

    // Per-cycle increment requests for the counter bank.
    always_comb begin
        stat_inc                = '0;
        stat_inc[STAT_CYCLE]    = (state_q != HZ_HALTED);
        stat_inc[STAT_STALL]    = (state_q == HZ_RUN) && lu_raw;
        stat_inc[STAT_FLUSH]    = (state_q == HZ_RUN) && jp_success;
        stat_inc[STAT_REDIRECT] = (state_q == HZ_RUN) && any_redirect_raw;
    end

    generate
        for (genvar gi = 0; gi < STAT_NUM; gi++) begin : g_stat
            hazard_stat_cnt #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk    (clk),
                .rst_n  (rst_n),
                .clear_n(1'b1),
                .inc    (stat_inc[gi]),
                .count  (stat_val[gi])
            );
        end
    endgenerate

    assign cycle_cnt    = stat_val[STAT_CYCLE];
    assign stall_cnt    = stat_val[STAT_STALL];
    assign flush_cnt    = stat_val[STAT_FLUSH];
    assign redirect_cnt = stat_val[STAT_REDIRECT];
`else
    // Without statistics, jp_success and the redirect summary have no sink.
    logic unused_stat_inputs;
    assign unused_stat_inputs = jp_success ^ any_redirect_raw;

    assign cycle_cnt    = '0;
    assign stall_cnt    = '0;
    assign flush_cnt    = '0;
    assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_hazard_ctrl;

    localparam int CNT_W        = 4;
    localparam int DRAIN_CYCLES = 2;
`ifdef HAZ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [4:0]       rs_id, rt_id, req_w_id_ex, req_w_ex_dm;
    logic             rs_used, rt_used, w_en_id_ex, memtoreg_id_ex, w_en_ex_dm;
    logic             jp_success, halt_req, go;
    logic             load_use, redirect_regA_ex_dm, redirect_regA_dm_wb;
    logic             redirect_regB_ex_dm, redirect_regB_dm_wb;
    logic             en_pc, en_if_id, en_id_ex, halted;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt, redirect_cnt;

    hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_id(rs_id), .rt_id(rt_id), .rs_used(rs_used), .rt_used(rt_used),
        .req_w_id_ex(req_w_id_ex), .w_en_id_ex(w_en_id_ex), .memtoreg_id_ex(memtoreg_id_ex),
        .req_w_ex_dm(req_w_ex_dm), .w_en_ex_dm(w_en_ex_dm),
        .jp_success(jp_success), .halt_req(halt_req), .go(go),
        .load_use(load_use),
        .redirect_regA_ex_dm(redirect_regA_ex_dm), .redirect_regA_dm_wb(redirect_regA_dm_wb),
        .redirect_regB_ex_dm(redirect_regB_ex_dm), .redirect_regB_dm_wb(redirect_regB_dm_wb),
        .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex), .halted(halted),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = running, 1 = draining, 2 = halted
    int          m_mode = 0;
    int          m_drain_left = 0;
    int unsigned m_cyc = 0, m_stall = 0, m_flush = 0, m_redir = 0;
    bit          e_lu, e_aex, e_bex, e_awb, e_bwb;

    function automatic bit hit(logic [4:0] s, logic u, logic [4:0] d, logic w);
        return u && w && (s != 0) && (s == d);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_drain_left = 0;
        m_cyc = 0; m_stall = 0; m_flush = 0; m_redir = 0;
    endtask

    // Derive the rule-level expectations from the current inputs.
    task automatic model_eval();
        bit a1, b1, a2, b2;
        a1 = hit(rs_id, rs_used, req_w_id_ex, w_en_id_ex);
        b1 = hit(rt_id, rt_used, req_w_id_ex, w_en_id_ex);
        a2 = hit(rs_id, rs_used, req_w_ex_dm, w_en_ex_dm);
        b2 = hit(rt_id, rt_used, req_w_ex_dm, w_en_ex_dm);
        e_lu  = (a1 || b1) && memtoreg_id_ex;
        e_aex = a1 && !memtoreg_id_ex;
        e_bex = b1 && !memtoreg_id_ex;
        e_awb = a2 && !e_aex;
        e_bwb = b2 && !e_bex;
    endtask

    task automatic model_clock();
        model_eval();
        case (m_mode)
            0: begin
                m_cyc++;
                if (e_lu) m_stall++;
                if (jp_success) m_flush++;
                if (e_aex || e_bex || e_awb || e_bwb) m_redir++;
                if (halt_req) begin m_mode = 1; m_drain_left = DRAIN_CYCLES; end
            end
            1: begin
                m_cyc++;
                m_drain_left--;
                if (m_drain_left == 0) m_mode = 2;
            end
            default: if (go) m_mode = 0;
        endcase
    endtask

    function automatic logic [31:0] exp_cnt(int unsigned c);
        return STATS ? (c % (1 << CNT_W)) : 32'd0;
    endfunction

    task automatic check_outputs(input string tag);
        bit drain;
        model_eval();
        drain = (m_mode == 1);
        if (m_mode != 2) begin
            check_eq({tag, ".load_use"}, load_use,            drain ? 1'b0 : e_lu);
            check_eq({tag, ".rA_exdm"},  redirect_regA_ex_dm, drain ? 1'b0 : e_aex);
            check_eq({tag, ".rB_exdm"},  redirect_regB_ex_dm, drain ? 1'b0 : e_bex);
            check_eq({tag, ".rA_dmwb"},  redirect_regA_dm_wb, drain ? 1'b0 : e_awb);
            check_eq({tag, ".rB_dmwb"},  redirect_regB_dm_wb, drain ? 1'b0 : e_bwb);
        end
        check_eq({tag, ".en_pc"},    en_pc,    (m_mode == 0) && !e_lu);
        check_eq({tag, ".en_if_id"}, en_if_id, (m_mode == 0) && !e_lu);
        check_eq({tag, ".en_id_ex"}, en_id_ex, m_mode != 2);
        check_eq({tag, ".halted"},   halted,   m_mode == 2);
        check_eq({tag, ".cycle"},    32'(cycle_cnt),    exp_cnt(m_cyc));
        check_eq({tag, ".stall"},    32'(stall_cnt),    exp_cnt(m_stall));
        check_eq({tag, ".flush"},    32'(flush_cnt),    exp_cnt(m_flush));
        check_eq({tag, ".redir"},    32'(redirect_cnt), exp_cnt(m_redir));
    endtask

    // Called 4 time units after a rising edge with inputs already settled.
    task automatic txn(input string tag);
        check_outputs(tag);
        $display("[TB] txn %0d %s mode=%0d lu=%0b en_pc=%0b halted=%0b cyc=%0d",
                 n_txn, tag, m_mode, load_use, en_pc, halted, cycle_cnt);
        n_txn++;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic clear_inputs();
        rs_id = 0; rt_id = 0; rs_used = 0; rt_used = 0;
        req_w_id_ex = 0; w_en_id_ex = 0; memtoreg_id_ex = 0;
        req_w_ex_dm = 0; w_en_ex_dm = 0;
        jp_success = 0; halt_req = 0; go = 0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        #12;
        check_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); model_clock(); #1;

        // Load-use: lw $8 in ID/EX, add $9,$8,$10 in ID.
        rs_id = 8; rt_id = 10; rs_used = 1; rt_used = 1;
        req_w_id_ex = 8; w_en_id_ex = 1; memtoreg_id_ex = 1;
        #3;
        check_eq("lu.flag", load_use, 1'b1);
        check_eq("lu.en_pc", en_pc, 1'b0);
        txn("lu");
        // Load now in EX/DM, bubble in ID/EX.
        w_en_id_ex = 0; memtoreg_id_ex = 0; req_w_id_ex = 0;
        req_w_ex_dm = 8; w_en_ex_dm = 1;
        #3;
        check_eq("lu_next.rA_dmwb", redirect_regA_dm_wb, 1'b1);
        check_eq("lu_next.lu", load_use, 1'b0);
        txn("lu_next");

        // Both producers write $5: younger wins for both sources.
        rs_id = 5; rt_id = 5; req_w_id_ex = 5; req_w_ex_dm = 5;
        w_en_id_ex = 1; w_en_ex_dm = 1; memtoreg_id_ex = 0;
        #3;
        check_eq("dbl.rA_exdm", redirect_regA_ex_dm, 1'b1);
        check_eq("dbl.rB_dmwb", redirect_regB_dm_wb, 1'b0);
        txn("dbl");

        // $0 never matches.
        clear_inputs();
        rs_used = 1; w_en_id_ex = 1; w_en_ex_dm = 1;
        #3; txn("zero");
        // Unused source never matches.
        rs_id = 7; rs_used = 0; req_w_id_ex = 7; memtoreg_id_ex = 1;
        #3; txn("unused");

        // Halt with simultaneous flush and load-use, then drain with live matches.
        rs_id = 5; rs_used = 1; req_w_id_ex = 5; memtoreg_id_ex = 1;
        halt_req = 1; jp_success = 1;
        #3; txn("halt");
        halt_req = 0; jp_success = 0; memtoreg_id_ex = 0;
        req_w_ex_dm = 5; rt_id = 5; rt_used = 1;
        #3;
        check_eq("drain0.rA_exdm", redirect_regA_ex_dm, 1'b0);
        txn("drain0");
        go = 1;
        #3; txn("drain1_go_ignored");
        go = 0;
        #3; check_eq("halt.halted", halted, 1'b1); txn("halted0");
        #3; txn("halted1");
        go = 1;
        #3; txn("go");
        go = 0;
        #3; check_eq("resume.halted", halted, 1'b0); txn("resume");

        // Asynchronous reset in the middle of DRAIN.
        clear_inputs();
        halt_req = 1;
        #3; txn("halt2");
        halt_req = 0;
        #3; txn("drain_a");
        #2; rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        #1; rst_n = 1'b1;
        @(posedge clk); model_clock(); #1;

        // Randomized traffic over a small register window to force overlaps.
        for (int i = 0; i < 300; i++) begin
            rs_id = 5'($urandom_range(0, 3));
            rt_id = 5'($urandom_range(0, 3));
            req_w_id_ex = 5'($urandom_range(0, 3));
            req_w_ex_dm = 5'($urandom_range(0, 3));
            rs_used = 1'($urandom); rt_used = 1'($urandom);
            w_en_id_ex = 1'($urandom); w_en_ex_dm = 1'($urandom);
            memtoreg_id_ex = ($urandom_range(0, 2) == 0);
            jp_success = ($urandom_range(0, 3) == 0);
            halt_req = ($urandom_range(0, 19) == 0);
            go = ($urandom_range(0, 3) == 0);
            #3; txn("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
